// File: rtl/game_sequencer_if.sv
// rtl/game_sequencer_if.sv - request/done handshake between sequencer and result checker
interface game_sequencer_if;
  logic        gradeReq;
  logic [11:0] guessOut;
  logic        gradeDone;
  logic [3:0]  Znarly;

  modport master (output gradeReq, guessOut, input gradeDone, Znarly);
  modport slave  (input gradeReq, guessOut, output gradeDone, Znarly);
endinterface

// File: rtl/game_sequencer.sv
// rtl/game_sequencer.sv - credit/purchase bookkeeping and per-game round sequencing
module game_sequencer #(
  parameter int COST       = 4,
  parameter int MAX_ROUNDS = 8,
  parameter int MAX_GAMES  = 7
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [1:0]  CoinValue,
  input  logic        CoinInserted,
  input  logic        StartGame,
  input  logic        LoadShapeNow,
  input  logic [2:0]  LoadShape,
  input  logic [1:0]  ShapeLocation,
  input  logic        GradeIt,
  input  logic [11:0] Guess,
  input  logic        debug,
  game_sequencer_if.master chk,
  output logic [11:0] masterPattern,
  output logic [3:0]  credit,
  output logic [3:0]  NumGames,
  output logic [3:0]  RoundNumber,
  output logic        GameWon,
  output logic        GameOver,
  output logic        displayMasterPattern
);

  localparam logic [4:0] COST5 = 5'(COST);
  localparam logic [3:0] MAXR  = 4'(MAX_ROUNDS);
  localparam logic [3:0] MAXG  = 4'(MAX_GAMES);

  typedef enum logic [2:0] {IDLE, LOAD, PLAY, GRADE, DONE} state_t;
  state_t state, state_nx;

  logic [3:0]  mask, mask_nx;
  logic [11:0] mp_nx, guess_nx;
  logic [3:0]  credit_nx, games_nx, round_nx;
  logic        won_nx, over_nx, req_nx, disp_nx;
  logic [4:0]  coin, sum;
  logic        buy, start;

  always_comb begin
    coin = 5'd0;
    if (CoinInserted) begin
      case (CoinValue)
        2'b00:   coin = 5'd0;
        2'b01:   coin = 5'd1;
        2'b10:   coin = 5'd2;
        default: coin = 5'd5;
      endcase
    end
    buy       = ({1'b0, credit} >= COST5) && (NumGames < MAXG);
    sum       = {1'b0, credit} - (buy ? COST5 : 5'd0) + coin;
    credit_nx = (sum > 5'd15) ? 4'd15 : sum[3:0];
    // a game bought and a game started in the same cycle cancel out
    start     = StartGame && (NumGames != 4'd0) && (state == IDLE || state == DONE);
    games_nx  = NumGames + {3'd0, buy} - {3'd0, start};

    state_nx = state;
    mask_nx  = mask;
    mp_nx    = masterPattern;
    guess_nx = chk.guessOut;
    req_nx   = chk.gradeReq;
    round_nx = RoundNumber;
    won_nx   = GameWon;
    over_nx  = GameOver;

    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_nx = LOAD;
          mask_nx  = 4'd0;
          mp_nx    = 12'd0;
          round_nx = 4'd0;
          won_nx   = 1'b0;
          over_nx  = 1'b0;
        end else if (StartGame && state == DONE) begin
          state_nx = IDLE;
        end
      end
      LOAD: begin
        if (LoadShapeNow && LoadShape != 3'd0) begin
          mp_nx[3*int'(ShapeLocation) +: 3] = LoadShape;
          mask_nx[ShapeLocation]            = 1'b1;
        end
        if (mask == 4'b1111) state_nx = PLAY;
      end
      PLAY: begin
        if (GradeIt && Guess[2:0] != 3'd0 && Guess[5:3] != 3'd0 &&
            Guess[8:6] != 3'd0 && Guess[11:9] != 3'd0) begin
          guess_nx = Guess;
          req_nx   = 1'b1;
          state_nx = GRADE;
        end
      end
      GRADE: begin
        if (chk.gradeDone) begin
          req_nx   = 1'b0;
          round_nx = RoundNumber + 4'd1;
          if (chk.Znarly == 4'd4) begin
            won_nx   = 1'b1;
            over_nx  = 1'b1;
            state_nx = DONE;
          end else if (round_nx == MAXR) begin
            over_nx  = 1'b1;
            state_nx = DONE;
          end else begin
            state_nx = PLAY;
          end
        end
      end
      default: state_nx = IDLE;
    endcase

    // keyed off the next state so the reveal lines up with GameOver
    disp_nx = (state_nx == DONE) || debug;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state                <= IDLE;
      mask                 <= 4'd0;
      masterPattern        <= 12'd0;
      credit               <= 4'd0;
      NumGames             <= 4'd0;
      RoundNumber          <= 4'd0;
      GameWon              <= 1'b0;
      GameOver             <= 1'b0;
      displayMasterPattern <= 1'b0;
      chk.gradeReq         <= 1'b0;
      chk.guessOut         <= 12'd0;
    end else begin
      state                <= state_nx;
      mask                 <= mask_nx;
      masterPattern        <= mp_nx;
      credit               <= credit_nx;
      NumGames             <= games_nx;
      RoundNumber          <= round_nx;
      GameWon              <= won_nx;
      GameOver             <= over_nx;
      displayMasterPattern <= disp_nx;
      chk.gradeReq         <= req_nx;
      chk.guessOut         <= guess_nx;
    end
  end

endmodule

// File: tb/tb_game_sequencer.sv
// tb/tb_game_sequencer.sv - directed self-checking bench for game_sequencer
module tb_game_sequencer;
  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [1:0]  CoinValue = 2'd0;
  logic        CoinInserted = 1'b0;
  logic        StartGame = 1'b0;
  logic        LoadShapeNow = 1'b0;
  logic [2:0]  LoadShape = 3'd0;
  logic [1:0]  ShapeLocation = 2'd0;
  logic        GradeIt = 1'b0;
  logic [11:0] Guess = 12'd0;
  logic        debug = 1'b0;
  logic [11:0] masterPattern;
  logic [3:0]  credit, NumGames, RoundNumber;
  logic        GameWon, GameOver, displayMasterPattern;

  int total = 0;
  int bad   = 0;

  game_sequencer_if chk_if ();

  game_sequencer dut (
    .clock(clock), .reset(reset), .CoinValue(CoinValue), .CoinInserted(CoinInserted),
    .StartGame(StartGame), .LoadShapeNow(LoadShapeNow), .LoadShape(LoadShape),
    .ShapeLocation(ShapeLocation), .GradeIt(GradeIt), .Guess(Guess), .debug(debug),
    .chk(chk_if.master), .masterPattern(masterPattern), .credit(credit),
    .NumGames(NumGames), .RoundNumber(RoundNumber), .GameWon(GameWon),
    .GameOver(GameOver), .displayMasterPattern(displayMasterPattern)
  );

  always #5 clock = ~clock;

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic coin(input logic [1:0] v);
    CoinInserted = 1'b1; CoinValue = v;
    tick();
    CoinInserted = 1'b0; CoinValue = 2'd0;
  endtask

  task automatic load_pattern;
    LoadShapeNow = 1'b1;
    for (int s = 0; s < 4; s++) begin
      ShapeLocation = 2'(s); LoadShape = 3'(s + 1);
      tick();
    end
    LoadShapeNow = 1'b0; LoadShape = 3'd0;
    tick();
  endtask

  task automatic test_reset;
    reset = 1'b0;
    #3;
    total++;
    if ({chk_if.gradeReq, chk_if.guessOut, masterPattern, credit, NumGames, RoundNumber,
         GameWon, GameOver, displayMasterPattern} !== 44'd0) begin
      bad++; $display("FAIL reset_async outputs not all zero");
    end
    tick(); tick();
    reset = 1'b1;
    tick();
    total++;
    if ({credit, NumGames, chk_if.gradeReq, displayMasterPattern} !== 10'd0) begin
      bad++; $display("FAIL reset_release got=%0h exp=0", {credit, NumGames, chk_if.gradeReq, displayMasterPattern});
    end
  endtask

  task automatic test_coins;
    logic [3:0] exp_c [3];
    logic [1:0] vals  [3];
    exp_c = '{4'd1, 4'd2, 4'd7};
    vals  = '{2'b01, 2'b01, 2'b11};
    for (int i = 0; i < 3; i++) begin
      coin(vals[i]);
      total++;
      if (credit !== exp_c[i] || NumGames !== 4'd0) begin
        bad++; $display("FAIL coin_%0d credit=%0d games=%0d exp credit=%0d games=0", i, credit, NumGames, exp_c[i]);
      end
    end
    tick();
    total++;
    if (credit !== 4'd3 || NumGames !== 4'd1) begin
      bad++; $display("FAIL purchase credit=%0d games=%0d exp 3/1", credit, NumGames);
    end
  endtask

  task automatic test_game_win;
    int hi;
    StartGame = 1'b1; tick(); StartGame = 1'b0;
    total++;
    if (NumGames !== 4'd0 || masterPattern !== 12'd0) begin
      bad++; $display("FAIL start_game games=%0d mp=%0h exp 0/0", NumGames, masterPattern);
    end
    LoadShapeNow = 1'b1;
    ShapeLocation = 2'd0; LoadShape = 3'd1; tick();
    ShapeLocation = 2'd1; LoadShape = 3'd0; tick();
    total++;
    if (masterPattern !== 12'h001) begin
      bad++; $display("FAIL illegal_shape mp=%0h exp=001", masterPattern);
    end
    ShapeLocation = 2'd1; LoadShape = 3'd2; tick();
    ShapeLocation = 2'd2; LoadShape = 3'd3; tick();
    ShapeLocation = 2'd3; LoadShape = 3'd4; tick();
    LoadShapeNow = 1'b0; LoadShape = 3'd0;
    tick();
    total++;
    if (masterPattern !== 12'b100_011_010_001) begin
      bad++; $display("FAIL pattern mp=%0h exp=8d1", masterPattern);
    end
    GradeIt = 1'b1; Guess = 12'h248; tick();
    total++;
    if (chk_if.gradeReq !== 1'b0) begin
      bad++; $display("FAIL illegal_guess gradeReq=%0b exp=0", chk_if.gradeReq);
    end
    Guess = 12'h249; tick(); GradeIt = 1'b0;
    hi = chk_if.gradeReq ? 1 : 0;
    total++;
    if (chk_if.guessOut !== 12'h249) begin
      bad++; $display("FAIL guess_latch got=%0h exp=249", chk_if.guessOut);
    end
    chk_if.Znarly = 4'd2;
    for (int i = 0; i < 6; i++) begin
      chk_if.gradeDone = (i == 3);
      tick();
      if (chk_if.gradeReq) hi++;
    end
    chk_if.gradeDone = 1'b0;
    total++;
    if (hi != 4 || RoundNumber !== 4'd1 || GameOver !== 1'b0) begin
      bad++; $display("FAIL grade_wait hi=%0d round=%0d over=%0b exp 4/1/0", hi, RoundNumber, GameOver);
    end
    GradeIt = 1'b1; tick(); GradeIt = 1'b0;
    chk_if.gradeDone = 1'b1; chk_if.Znarly = 4'd4; tick();
    chk_if.gradeDone = 1'b0;
    total++;
    if ({chk_if.gradeReq, RoundNumber, GameWon, GameOver, displayMasterPattern} !== 8'b0_0010_111) begin
      bad++; $display("FAIL win got=%b exp=00010111", {chk_if.gradeReq, RoundNumber, GameWon, GameOver, displayMasterPattern});
    end
  endtask

  task automatic test_lose;
    coin(2'b01); tick();
    total++;
    if (credit !== 4'd0 || NumGames !== 4'd1) begin
      bad++; $display("FAIL rebuy credit=%0d games=%0d exp 0/1", credit, NumGames);
    end
    StartGame = 1'b1; tick(); StartGame = 1'b0;
    total++;
    if ({NumGames, RoundNumber, GameWon, GameOver, displayMasterPattern} !== 11'd0) begin
      bad++; $display("FAIL restart_clear got=%b exp=0", {NumGames, RoundNumber, GameWon, GameOver, displayMasterPattern});
    end
    load_pattern();
    Guess = 12'h249; chk_if.Znarly = 4'd3;
    for (int r = 0; r < 8; r++) begin
      GradeIt = 1'b1; tick(); GradeIt = 1'b0;
      chk_if.gradeDone = 1'b1; tick(); chk_if.gradeDone = 1'b0;
      total++;
      if (RoundNumber !== 4'(r + 1) || GameOver !== (r == 7)) begin
        bad++; $display("FAIL round_%0d round=%0d over=%0b", r, RoundNumber, GameOver);
      end
    end
    total++;
    if (GameWon !== 1'b0 || displayMasterPattern !== 1'b1) begin
      bad++; $display("FAIL lost won=%0b disp=%0b exp 0/1", GameWon, displayMasterPattern);
    end
    StartGame = 1'b1; tick(); StartGame = 1'b0;
    total++;
    if ({RoundNumber, GameOver, displayMasterPattern, masterPattern} !== {4'd8, 1'b1, 1'b0, 12'h8d1}) begin
      bad++; $display("FAIL to_idle round=%0d over=%0b disp=%0b mp=%0h", RoundNumber, GameOver, displayMasterPattern, masterPattern);
    end
    debug = 1'b1; tick(); debug = 1'b0;
    total++;
    if (displayMasterPattern !== 1'b1) begin
      bad++; $display("FAIL debug disp=%0b exp=1", displayMasterPattern);
    end
  endtask

  task automatic test_saturate;
    reset = 1'b0; #2; reset = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) coin(2'b11);
    total++;
    if (credit !== 4'd12 || NumGames !== 4'd7) begin
      bad++; $display("FAIL buy_burst credit=%0d games=%0d exp 12/7", credit, NumGames);
    end
    coin(2'b10);
    total++;
    if (credit !== 4'd14) begin
      bad++; $display("FAIL credit14 credit=%0d exp=14", credit);
    end
    coin(2'b11);
    tick();
    total++;
    if (credit !== 4'd15 || NumGames !== 4'd7) begin
      bad++; $display("FAIL saturate credit=%0d games=%0d exp 15/7", credit, NumGames);
    end
  endtask

  task automatic test_reset_mid_grade;
    StartGame = 1'b1; tick(); StartGame = 1'b0;
    load_pattern();
    GradeIt = 1'b1; Guess = 12'h249; tick(); GradeIt = 1'b0;
    total++;
    if (chk_if.gradeReq !== 1'b1) begin
      bad++; $display("FAIL mid_req gradeReq=%0b exp=1", chk_if.gradeReq);
    end
    #2 reset = 1'b0;
    #1;
    total++;
    if ({chk_if.gradeReq, chk_if.guessOut, masterPattern, credit, NumGames, RoundNumber,
         GameWon, GameOver, displayMasterPattern} !== 44'd0) begin
      bad++; $display("FAIL mid_reset outputs not all zero");
    end
    reset = 1'b1;
    chk_if.gradeDone = 1'b1; chk_if.Znarly = 4'd4;
    tick(); tick();
    chk_if.gradeDone = 1'b0;
    total++;
    if ({chk_if.gradeReq, RoundNumber, GameWon, GameOver} !== 7'd0) begin
      bad++; $display("FAIL late_done got=%b exp=0", {chk_if.gradeReq, RoundNumber, GameWon, GameOver});
    end
  endtask

  initial begin
    chk_if.gradeDone = 1'b0;
    chk_if.Znarly    = 4'd0;
    test_reset();
    test_coins();
    test_game_win();
    test_lose();
    test_saturate();
    test_reset_mid_grade();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1);
  end
endmodule
